// File: rtl/hsclk_div_gen.sv
// rtl/hsclk_div_gen.sv - glitch-free 50% duty hsclk /2,/4,/6,/8 CPU clock generator with park-low stop
// Optional input synchronisers enabled by defining HSCLK_DIV_SYNC_EN.
module hsclk_div_gen (
   input  logic       hsclk,
   input  logic       resetb,
   input  logic [1:0] cpuclk_div_sel,
   input  logic       stop_req,
   output logic       div_clk,
   output logic       stopped,
   output logic       hs_selected
);

   logic [1:0] sel_s;
   logic       stop_s;

`ifdef HSCLK_DIV_SYNC_EN
   logic [1:0] sel_meta_q;
   logic [1:0] sel_sync_q;
   logic       stop_meta_q;
   logic       stop_sync_q;

   always_ff @(posedge hsclk or negedge resetb) begin
      if (!resetb) begin
         sel_meta_q  <= 2'b00;
         sel_sync_q  <= 2'b00;
         stop_meta_q <= 1'b0;
         stop_sync_q <= 1'b0;
      end else begin
         sel_meta_q  <= cpuclk_div_sel;
         sel_sync_q  <= sel_meta_q;
         stop_meta_q <= stop_req;
         stop_sync_q <= stop_meta_q;
      end
   end

   assign sel_s  = sel_sync_q;
   assign stop_s = stop_sync_q;
`else
   assign sel_s  = cpuclk_div_sel;
   assign stop_s = stop_req;
`endif

   logic       div_clk_q,     div_clk_d;
   logic [1:0] cnt_q,         cnt_d;
   logic [2:0] half_q,        half_d;
   logic       stopped_q,     stopped_d;
   logic       hs_selected_q, hs_selected_d;
   logic [2:0] half_m1;

   assign half_m1 = half_q - 3'd1;

   // Divisor is only sampled at the falling edge, so a low+high pair never mixes rates.
   always_comb begin
      div_clk_d = div_clk_q;
      cnt_d     = cnt_q;
      half_d    = half_q;
      stopped_d = stopped_q;
      if (cnt_q != 2'd0) begin
         cnt_d = cnt_q - 2'd1;
      end else if (div_clk_q) begin
         div_clk_d = 1'b0;
         half_d    = {1'b0, sel_s} + 3'd1;
         cnt_d     = sel_s;
      end else if (stop_s) begin
         stopped_d = 1'b1;
      end else begin
         div_clk_d = 1'b1;
         cnt_d     = half_m1[1:0];
         stopped_d = 1'b0;
      end
      hs_selected_d = !stopped_d;
   end

   always_ff @(posedge hsclk or negedge resetb) begin
      if (!resetb) begin
         div_clk_q     <= 1'b0;
         cnt_q         <= 2'd0;
         half_q        <= 3'd1;
         stopped_q     <= 1'b1;
         hs_selected_q <= 1'b0;
      end else begin
         div_clk_q     <= div_clk_d;
         cnt_q         <= cnt_d;
         half_q        <= half_d;
         stopped_q     <= stopped_d;
         hs_selected_q <= hs_selected_d;
      end
   end

   assign div_clk     = div_clk_q;
   assign stopped     = stopped_q;
   assign hs_selected = hs_selected_q;

endmodule
